// File: rtl/system_memcopy_pkg.sv
// Shared state encoding and default widths for the on-chip memory copy engine.
package system_memcopy_pkg;

  localparam int MEMCOPY_ADDR_W = 12;
  localparam int MEMCOPY_DATA_W = 32;

  typedef enum logic [2:0] {
    IDLE,
    READ,
    WAIT,
    WRITE,
    DONE
  } memcopyState_t;

endpackage

// File: rtl/system_onchip_memcopy_if.sv
// Control handshake and Avalon-MM bus bundles for the memory copy engine.
interface system_memcopy_ctrl_if
  import system_memcopy_pkg::*;
#(
  parameter int ADDR_W = MEMCOPY_ADDR_W
);

  logic              start;
  logic [ADDR_W-1:0] src_addr;
  logic [ADDR_W-1:0] dst_addr;
  logic [ADDR_W:0]   length;
  logic              abort;
  logic              busy;
  logic              done;

  modport master (
    output start, src_addr, dst_addr, length, abort,
    input  busy, done
  );

  modport slave (
    input  start, src_addr, dst_addr, length, abort,
    output busy, done
  );

endinterface

interface system_memcopy_avm_if
  import system_memcopy_pkg::*;
#(
  parameter int ADDR_W = MEMCOPY_ADDR_W,
  parameter int DATA_W = MEMCOPY_DATA_W
);

  logic [ADDR_W-1:0]   m_address;
  logic [DATA_W/8-1:0] m_byteenable;
  logic                m_chipselect;
  logic                m_clken;
  logic                m_write;
  logic [DATA_W-1:0]   m_writedata;
  logic [DATA_W-1:0]   m_readdata;

  modport master (
    output m_address, m_byteenable, m_chipselect, m_clken, m_write, m_writedata,
    input  m_readdata
  );

  modport slave (
    input  m_address, m_byteenable, m_chipselect, m_clken, m_write, m_writedata,
    output m_readdata
  );

endinterface

// File: rtl/system_memcopy_addr_gen.sv
// Read/write pointer and remaining-count tracking with overlap-safe direction choice.
module system_memcopy_addr_gen
  import system_memcopy_pkg::*;
#(
  parameter int ADDR_W = MEMCOPY_ADDR_W
)
(
  input  logic              clk,
  input  logic              reset_n,
  input  logic              i_load,
  input  logic              i_step,
  input  logic [ADDR_W-1:0] i_src,
  input  logic [ADDR_W-1:0] i_dst,
  input  logic [ADDR_W:0]   i_len,
  output logic [ADDR_W-1:0] o_rdNext,
  output logic [ADDR_W-1:0] o_wrPtr,
  output logic              o_last
);

  logic [ADDR_W-1:0] r_rdPtr;
  logic [ADDR_W-1:0] r_wrPtr;
  logic [ADDR_W:0]   r_remain;
  logic              r_desc;

  logic [ADDR_W-1:0] w_diff;
  logic [ADDR_W-1:0] w_span;
  logic [ADDR_W-1:0] w_rdStart;
  logic [ADDR_W-1:0] w_wrStart;
  logic [ADDR_W-1:0] w_rdStep;
  logic [ADDR_W-1:0] w_wrStep;
  logic              w_desc;

  // Copy backwards only when the destination starts inside the source block.
  assign w_diff    = i_dst - i_src;
  assign w_desc    = (w_diff != '0) && ({1'b0, w_diff} < i_len);
  assign w_span    = i_len[ADDR_W-1:0] - ADDR_W'(1);
  assign w_rdStart = w_desc ? (i_src + w_span) : i_src;
  assign w_wrStart = w_desc ? (i_dst + w_span) : i_dst;
  assign w_rdStep  = r_desc ? (r_rdPtr - ADDR_W'(1)) : (r_rdPtr + ADDR_W'(1));
  assign w_wrStep  = r_desc ? (r_wrPtr - ADDR_W'(1)) : (r_wrPtr + ADDR_W'(1));

  // Next read address lets the top register m_address in the same edge as the pointer.
  assign o_rdNext = i_load ? w_rdStart : (i_step ? w_rdStep : r_rdPtr);
  assign o_wrPtr  = r_wrPtr;
  assign o_last   = (r_remain == (ADDR_W+1)'(1));

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_rdPtr  <= '0;
      r_wrPtr  <= '0;
      r_remain <= '0;
      r_desc   <= 1'b0;
    end else if (i_load) begin
      r_rdPtr  <= w_rdStart;
      r_wrPtr  <= w_wrStart;
      r_remain <= i_len;
      r_desc   <= w_desc;
    end else if (i_step) begin
      r_rdPtr  <= w_rdStep;
      r_wrPtr  <= w_wrStep;
      r_remain <= r_remain - (ADDR_W+1)'(1);
    end
  end

endmodule

// File: rtl/system_onchip_memcopy.sv
// Avalon-MM block copy engine for the on-chip RAM, three cycles per word.
// Optional running checksum of copied words: SYSTEM_MEMCOPY_CHECKSUM_EN.
module system_onchip_memcopy
  import system_memcopy_pkg::*;
#(
  parameter int ADDR_W = MEMCOPY_ADDR_W,
  parameter int DATA_W = MEMCOPY_DATA_W
)
(
  input logic                  clk,
  input logic                  reset_n,
  system_memcopy_ctrl_if.slave ctrl,
  system_memcopy_avm_if.master avm
`ifdef SYSTEM_MEMCOPY_CHECKSUM_EN
  ,
  output logic [DATA_W-1:0]    checksum
`endif
);

  memcopyState_t r_state;
  logic              r_busy;
  logic              r_done;
  logic [ADDR_W-1:0] r_address;
  logic              r_chipselect;
  logic              r_clken;
  logic              r_write;
  logic [DATA_W-1:0] r_writedata;

  logic              w_load;
  logic              w_step;
  logic              w_last;
  logic              w_abort;
  logic [ADDR_W-1:0] w_rdNext;
  logic [ADDR_W-1:0] w_wrPtr;

  assign w_load  = (r_state == IDLE) && ctrl.start;
  assign w_step  = (r_state == WRITE);
  assign w_abort = ctrl.abort && (r_state inside {READ, WAIT, WRITE});

  system_memcopy_addr_gen #(
    .ADDR_W (ADDR_W)
  ) u_addrGen (
    .clk      (clk),
    .reset_n  (reset_n),
    .i_load   (w_load),
    .i_step   (w_step),
    .i_src    (ctrl.src_addr),
    .i_dst    (ctrl.dst_addr),
    .i_len    (ctrl.length),
    .o_rdNext (w_rdNext),
    .o_wrPtr  (w_wrPtr),
    .o_last   (w_last)
  );

`ifdef SYSTEM_MEMCOPY_CHECKSUM_EN
  logic [DATA_W-1:0] r_checksum;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_checksum <= '0;
    end else if (w_load) begin
      r_checksum <= '0;
    end else if ((r_state == WAIT) && !ctrl.abort) begin
      r_checksum <= r_checksum + avm.m_readdata;
    end
  end

  assign checksum = r_checksum;
`endif

  // Bus outputs are set on the edge entering each state so they line up with it.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state      <= IDLE;
      r_busy       <= 1'b0;
      r_done       <= 1'b0;
      r_address    <= '0;
      r_chipselect <= 1'b0;
      r_clken      <= 1'b0;
      r_write      <= 1'b0;
      r_writedata  <= '0;
    end else if (w_abort) begin
      r_state      <= IDLE;
      r_busy       <= 1'b0;
      r_chipselect <= 1'b0;
      r_clken      <= 1'b0;
      r_write      <= 1'b0;
    end else begin
      case (r_state)
        IDLE: begin
          if (ctrl.start) begin
            r_busy  <= 1'b1;
            r_clken <= 1'b1;
            if (ctrl.length == '0) begin
              r_state <= DONE;
              r_done  <= 1'b1;
            end else begin
              r_state      <= READ;
              r_address    <= w_rdNext;
              r_chipselect <= 1'b1;
            end
          end
        end
        READ: begin
          r_state      <= WAIT;
          r_chipselect <= 1'b0;
        end
        WAIT: begin
          r_state      <= WRITE;
          r_writedata  <= avm.m_readdata;
          r_address    <= w_wrPtr;
          r_chipselect <= 1'b1;
          r_write      <= 1'b1;
        end
        WRITE: begin
          r_write <= 1'b0;
          if (w_last) begin
            r_state      <= DONE;
            r_done       <= 1'b1;
            r_chipselect <= 1'b0;
          end else begin
            r_state      <= READ;
            r_address    <= w_rdNext;
            r_chipselect <= 1'b1;
          end
        end
        DONE: begin
          r_state <= IDLE;
          r_done  <= 1'b0;
          r_busy  <= 1'b0;
          r_clken <= 1'b0;
        end
        default: begin
          r_state <= IDLE;
        end
      endcase
    end
  end

  assign ctrl.busy        = r_busy;
  assign ctrl.done        = r_done;
  assign avm.m_address    = r_address;
  assign avm.m_byteenable = '1;
  assign avm.m_chipselect = r_chipselect;
  assign avm.m_clken      = r_clken;
  assign avm.m_write      = r_write;
  assign avm.m_writedata  = r_writedata;

endmodule

// File: doc/system_onchip_memcopy.md
# system_onchip_memcopy

Avalon-MM initiator that copies a block of 32-bit words within the 4096×32 single-port on-chip memory. It drives the memory's slave port (address, byteenable, chipselect, clken, write, writedata, readdata) and is itself controlled by a start/busy/done handshake from the system controller. Copies are overlap-safe: copy direction is chosen so the source is never overwritten before it is read.

## Interface
Parameters:
- ADDR_W, 12, word-address width; memory depth is 2**ADDR_W.
- DATA_W, 32, data width; byteenable width is DATA_W/8.

Ports:
- clk  in  1  single clock for all logic.
- reset_n  in  1  asynchronous, active-low reset.
- start  in  1  request a copy; sampled only in IDLE.
- src_addr  in  ADDR_W  first source word; sampled with start.
- dst_addr  in  ADDR_W  first destination word; sampled with start.
- length  in  ADDR_W+1  word count, 0..4096; sampled with start.
- abort  in  1  cancel the copy in progress.
- busy  out  1  high from the cycle after an accepted start until return to IDLE.
- done  out  1  one-cycle pulse on normal completion.
- m_address  out  ADDR_W  memory word address.
- m_byteenable  out  DATA_W/8  always all-ones.
- m_chipselect  out  1  memory select.
- m_clken  out  1  memory clock enable.
- m_write  out  1  write strobe.
- m_writedata  out  DATA_W  write data.
- m_readdata  in  DATA_W  memory read data.

## Operation
- States: IDLE, READ, WAIT, WRITE, DONE.
- IDLE: start=1 latches src, dst, and length; length=0 goes to DONE, otherwise goes to READ. start while busy is ignored.
- Direction: descending when d=(dst−src) mod 2**ADDR_W satisfies 0<d<length. Otherwise ascending.
  - Ascending: the pointers start at src and dst and increment.
  - Descending: the pointers start at src+length−1 and dst+length−1 and decrement.
- All pointer arithmetic wraps modulo 2**ADDR_W.
- READ: m_address=rd_ptr, m_chipselect=1, m_write=0. Next state is WAIT.
- WAIT: m_readdata is valid. Capture it into the data register. Next state is WRITE.
- WRITE: m_address=wr_ptr, m_writedata=data register, m_chipselect=1, m_write=1. Step both pointers and decrement the remaining count. Next state is READ, or DONE when the count reaches 0.
- DONE: done=1 for one cycle, then IDLE.
- m_clken=1 whenever not in IDLE. m_chipselect and m_write are 0 in IDLE, WAIT and DONE.
- abort=1 in READ, WAIT or WRITE:
  - Next state is IDLE and done is not pulsed.
  - A write presented in the same cycle as abort still takes effect.
  - Words already written stay written.
- abort in IDLE or DONE has no effect.

## Timing
- Reset values: busy=0, done=0, m_address=0, m_byteenable=all-ones, m_chipselect=0, m_clken=0, m_write=0, m_writedata=0; state IDLE; checksum=0.
- Memory read latency is 1 cycle: the address registers at the edge closing READ, and data is sampled at the edge closing WAIT.
- All master outputs are registered, decoded from the state register.
- 3 cycles per word. With start accepted at edge 0, done is high in cycle 3·length+1 and busy falls the next cycle. length=0 gives done in cycle 1.
- reset_n asserted mid-copy returns the block to IDLE immediately, with outputs at reset values. The partially copied block is not restored.

## Configuration
- SYSTEM_MEMCOPY_CHECKSUM_EN defined:
  - Adds output checksum (DATA_W), the modulo-2**DATA_W sum of every word captured in WAIT.
  - The sum clears on an accepted start.
  - It holds its value after DONE or abort until the next start.
- Undefined: no checksum port or adder, and behaviour is otherwise identical.

## Structure
- Package system_memcopy_pkg: the state enum (IDLE, READ, WAIT, WRITE, DONE), and the ADDR_W/DATA_W defaults as localparams.
- One sub-module, system_memcopy_addr_gen. It holds the rd_ptr, wr_ptr and remaining-count registers, the direction decision, and the wrap arithmetic. It exposes load, step and last.
- The FSM and master-output registers stay in the top module.

## Test plan
- Ascending copy: memory preloaded with word i = 0x1000+i; src=0x010, dst=0x100, length=4 → words 0x100..0x103 = 0x1010..0x1013; done in cycle 13; source unchanged.
- Overlap, descending: src=0x020, dst=0x022, length=4, source words 0xA0..0xA3 → 0x022..0x025 = 0xA0..0xA3; the write order observed on the bus is 0x025, 0x024, 0x023, 0x022.
- Wrap-around: src=0xFFE, dst=0x010, length=4 → reads from 0xFFE, 0xFFF, 0x000, 0x001; writes to 0x010..0x013.
- Boundary length values:
  - length=0 → done in cycle 1, and no chipselect is ever asserted.
  - length=4096 with src=dst → 12289 cycles, memory unchanged.
- Abort: abort raised in the second WRITE of a length=8 copy → exactly 2 words written, no done, busy low the next cycle; a start held during the copy is ignored.
- Checksum (SYSTEM_MEMCOPY_CHECKSUM_EN): copy of 3 words 0xFFFFFFFF, 0x00000002, 0x00000010 → checksum=0x00000011.
- Reset mid-copy: reset_n low in WAIT → all outputs at reset values within the same cycle.
